// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the SPI slave receiver.
package spi_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } spi_state_e;

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through RX FIFO. A write while full is accepted only when a
// read pops the head in the same cycle; reads while empty are ignored.
module rx_fifo
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_accept,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_do_rd;
    logic                  w_do_wr;

    function automatic logic [ADDR_WIDTH-1:0] f_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (r_count == '0);
    assign full      = (r_count == DEPTH_C);
    assign w_do_rd   = rd_en & ~empty;
    // Full implies non-empty, so a same-cycle pop always frees the slot.
    assign w_do_wr   = wr_en & (~full | w_do_rd);
    assign wr_accept = w_do_wr;
    assign rd_data   = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            if (w_do_rd) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver (MSB first) feeding an FWFT RX FIFO.
// Define SPI_RX_SYNC_EN to put 2-flop synchronizers on sclk, mosi and cs_n.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  cs_n,
    input  logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    input  logic                  flag_clr,
    output logic                  overrun,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic                  w_sclk_s;
    logic                  w_mosi_s;
    logic                  w_csn_s;
    logic                  r_sclk_d;
    logic                  w_rise;
    spi_state_e            r_state;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  w_push;
    logic                  w_accept;
    logic                  r_overrun;
    logic                  r_frame_err;

`ifdef SPI_RX_SYNC_EN
    logic [1:0] r_sclk_sync;
    logic [1:0] r_mosi_sync;
    logic [1:0] r_csn_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_csn_sync  <= 2'b11;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], sclk};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
            r_csn_sync  <= {r_csn_sync[0], cs_n};
        end
    end

    assign w_sclk_s = r_sclk_sync[1];
    assign w_mosi_s = r_mosi_sync[1];
    assign w_csn_s  = r_csn_sync[1];
`else
    assign w_sclk_s = sclk;
    assign w_mosi_s = mosi;
    assign w_csn_s  = cs_n;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_d <= 1'b0;
        end else begin
            r_sclk_d <= w_sclk_s;
        end
    end

    assign w_rise      = w_sclk_s & ~r_sclk_d;
    assign w_shift_nxt = {r_shift[DATA_WIDTH-2:0], w_mosi_s};
    // A deasserting cs_n takes priority over a coincident sclk rise.
    assign w_push      = (r_state == RECV) & ~w_csn_s & w_rise & (r_bit_cnt == LAST_BIT);

    // Later assignments win, so a set event beats flag_clr in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (flag_clr) begin
                r_overrun   <= 1'b0;
                r_frame_err <= 1'b0;
            end
            if (w_push && !w_accept) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (!w_csn_s) begin
                        r_state   <= RECV;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                    end
                end
                RECV: begin
                    if (w_csn_s) begin
                        r_state <= IDLE;
                        if (r_bit_cnt != '0) begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_rise) begin
                        r_shift   <= w_shift_nxt;
                        r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (w_push),
        .wr_data   (w_shift_nxt),
        .wr_accept (w_accept),
        .rd_en     (fifo_rd_en),
        .rd_data   (fifo_rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
    assign busy      = (r_state == RECV);

endmodule
